svc_rv_mem_arb: RTL

- Arbiter that shares one single-port SRAM between the RISC-V core's instruction-fetch port and its data port. This lets a SoC run from a unified code/data memory instead of separate imem/dmem.
- Grants at most one SRAM access per cycle: one read or one write.
- Stalls the losing requester through the core's existing imem_stall/dmem_stall inputs.
- Registers granted read data, so each requester sees the 1-cycle BRAM-style read latency.

---
 rtl/svc_rv_mem_arb.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/svc_rv_mem_arb.sv
// svc_rv_mem_arb
// Shares one single-port SRAM (combinational read data) between the core's
// instruction-fetch port and its data port. At most one SRAM access (one read
// or one write) is granted per cycle; the loser is stalled. Read data from a
// granted access is registered, so each requester sees a 1-cycle read latency.
//
// Grant priority, evaluated combinationally each cycle:
//   1. imem read, when it has been denied STARVE_MAX cycles in a row
//   2. data write (unless the write half of a write+read pair is already done)
//   3. data read
//   4. imem read
//
// dwr_first state (tracks a data write+read pair requested in the same cycle)
//   state | meaning
//   0     | no split data request in progress; dmem_we arbitrates normally
//   1     | write half already granted; dmem_we ignored until the read is granted
//
// STARVE_MAX must be in 1..255 because the starvation counter is 8 bits wide.

module svc_rv_mem_arb #(
  parameter int AW         = 32,
  parameter int DW         = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic            clk,
  input  logic            rst,

  input  logic            imem_ren,
  input  logic [AW-1:0]   imem_raddr,
  output logic [DW-1:0]   imem_rdata,
  output logic            imem_stall,

  input  logic            dmem_ren,
  input  logic [AW-1:0]   dmem_raddr,
  output logic [DW-1:0]   dmem_rdata,
  input  logic            dmem_we,
  input  logic [AW-1:0]   dmem_waddr,
  input  logic [DW-1:0]   dmem_wdata,
  input  logic [DW/8-1:0] dmem_wstrb,
  output logic            dmem_stall,

  output logic            mem_ren,
  output logic [AW-1:0]   mem_raddr,
  input  logic [DW-1:0]   mem_rdata,
  output logic            mem_we,
  output logic [AW-1:0]   mem_waddr,
  output logic [DW-1:0]   mem_wdata,
  output logic [DW/8-1:0] mem_wstrb
);

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_IMEM = 2'd1,
    GNT_DWR  = 2'd2,
    GNT_DRD  = 2'd3
  } gnt_t;

  localparam logic [7:0] STARVE_LIM = 8'(STARVE_MAX);

  logic [7:0] cnt;
  logic [7:0] cnt_next;
  logic       dwr_first;
  logic       dwr_first_next;
  gnt_t       gnt;
  logic       starve;
  logic       wr_req;
  logic       data_done;

  // State register: starvation counter and split write/read tracking
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt       <= 8'd0;
      dwr_first <= 1'b0;
    end else begin
      cnt       <= cnt_next;
      dwr_first <= dwr_first_next;
    end
  end

  // Registered read data: capture SRAM output at the end of a granted read
  always_ff @(posedge clk) begin
    if (rst) begin
      imem_rdata <= '0;
      dmem_rdata <= '0;
    end else begin
      if (gnt == GNT_IMEM) imem_rdata <= mem_rdata;
      if (gnt == GNT_DRD)  dmem_rdata <= mem_rdata;
    end
  end

  // Next-state: grant selection, counter and dwr_first updates
  always_comb begin
    starve = imem_ren && (cnt == STARVE_LIM);
    // Once the write half of a write+read pair is done the core still holds
    // dmem_we high (it is stalled), so it must be masked to let the read win.
    wr_req = dmem_we && !dwr_first;

    gnt = GNT_NONE;
    if (rst)           gnt = GNT_NONE;
    else if (starve)   gnt = GNT_IMEM;
    else if (wr_req)   gnt = GNT_DWR;
    else if (dmem_ren) gnt = GNT_DRD;
    else if (imem_ren) gnt = GNT_IMEM;

    cnt_next = cnt;
    if (gnt == GNT_IMEM || !imem_ren) begin
      cnt_next = 8'd0;
    end else if (cnt >= STARVE_LIM) begin
      cnt_next = STARVE_LIM;
    end else begin
      cnt_next = cnt + 8'd1;
    end

    dwr_first_next = dwr_first;
    if (gnt == GNT_DRD) begin
      dwr_first_next = 1'b0;
    end else if (gnt == GNT_DWR && dmem_ren) begin
      dwr_first_next = 1'b1;
    end
  end

  // Outputs: SRAM drive and requester stalls derived from the grant
  always_comb begin
    mem_ren   = (gnt == GNT_IMEM) || (gnt == GNT_DRD);
    mem_raddr = (gnt == GNT_DRD) ? dmem_raddr : imem_raddr;
    mem_we    = (gnt == GNT_DWR);
    mem_waddr = dmem_waddr;
    mem_wdata = dmem_wdata;
    mem_wstrb = dmem_wstrb;

    // The data port is released only when its whole request is complete: a
    // read grant, or a write grant that has no read riding along with it.
    data_done = (gnt == GNT_DRD) || ((gnt == GNT_DWR) && !dmem_ren);

    imem_stall = 1'b0;
    dmem_stall = 1'b0;
    if (!rst) begin
      imem_stall = imem_ren && (gnt != GNT_IMEM);
      dmem_stall = (dmem_ren || dmem_we) && !data_done;
    end
  end

  // Invariants: one SRAM access per cycle, no writes during reset, bounded counter
  always_ff @(posedge clk) begin
    assert (!(mem_ren && mem_we))
      else $error("svc_rv_mem_arb: read and write granted together");
    assert (!(rst && (mem_we || mem_ren)))
      else $error("svc_rv_mem_arb: SRAM access during reset");
    assert (rst || cnt <= STARVE_LIM)
      else $error("svc_rv_mem_arb: starvation counter out of range");
  end

endmodule
